execute_stage_pipe: RTL and testbench

- Registered, parametrised Y86-64 execute stage for the pipelined processor.
- Computes valE with a WIDTH-bit ALU and keeps the condition codes (ZF/SF/OF) in an internal register.
- Evaluates cmovXX/jXX conditions and presents one result per instruction downstream.
- Valid/ready handshakes on both sides; a cc_en input lets later stages inhibit CC updates.

---
 rtl/execute_stage_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_execute_stage_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_pipe.sv
// ----------------------------------------------------------------------------
// execute_stage_pipe
//   Registered Y86-64 execute stage. It computes valE with a WIDTH-bit ALU,
//   evaluates jXX/cmovXX conditions against the internal condition-code
//   register, and presents one result per instruction to the memory stage
//   through a valid/ready handshake.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid/ready  upstream handshake (in_ready is combinational)
//   icode, ifun     instruction and function codes
//   valA/valB/valC  register operands and instruction constant
//   dstE            destination register for valE
//   cc_en           1 lets an OPq update the condition codes
//   out_valid/ready downstream handshake
//   out_*           registered result: icode, valE, valA, dstE, cnd, err
//   cc_out          {ZF,SF,OF} condition-code register
// ----------------------------------------------------------------------------
module execute_stage_pipe #(
    parameter int         WIDTH      = 64,
    parameter int         STACK_STEP = 8,
    parameter logic [3:0] RNONE      = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    input  logic [3:0]       dstE,
    input  logic             cc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic [WIDTH-1:0] out_valE,
    output logic [WIDTH-1:0] out_valA,
    output logic [3:0]       out_dstE,
    output logic             out_cnd,
    output logic             out_err,
    output logic [2:0]       cc_out
);

    localparam int               MSB    = WIDTH - 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STACK_STEP);

    // Branch/move condition from the {ZF,SF,OF} flags; unknown codes are false.
    function automatic logic cond_eval_f(input logic [3:0] fn, input logic [2:0] cc);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (fn)
            4'h0:    res = 1'b1;
            4'h1:    res = (sf ^ of) | zf;
            4'h2:    res = sf ^ of;
            4'h3:    res = zf;
            4'h4:    res = ~zf;
            4'h5:    res = ~(sf ^ of);
            4'h6:    res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic             capture_s;
    logic             cond_s;
    logic [WIDTH-1:0] alu_s;
    logic             of_s;
    logic [WIDTH-1:0] vale_s;
    logic             cnd_s;
    logic             err_s;
    logic [3:0]       dste_s;
    logic             cc_we_s;
    logic [2:0]       cc_next_s;
    logic [2:0]       cc_r;

    assign in_ready  = !out_valid || out_ready;
    assign capture_s = in_valid && in_ready;
    // Conditions always see the flags as they stood before this capture edge,
    // which is exactly what an OPq in the previous cycle left in cc_r.
    assign cond_s    = cond_eval_f(ifun, cc_r);
    assign cc_next_s = {(alu_s == '0), alu_s[MSB], of_s};
    assign cc_out    = cc_r;

    // OPq ALU: result and signed-overflow flag for add/sub/and/xor.
    always_comb begin
        alu_s = '0;
        of_s  = 1'b0;
        case (ifun)
            4'h0: begin
                alu_s = valB + valA;
                of_s  = (valA[MSB] == valB[MSB]) && (alu_s[MSB] != valB[MSB]);
            end
            4'h1: begin
                alu_s = valB - valA;
                of_s  = (valA[MSB] != valB[MSB]) && (alu_s[MSB] != valB[MSB]);
            end
            4'h2: begin
                alu_s = valB & valA;
                of_s  = 1'b0;
            end
            4'h3: begin
                alu_s = valB ^ valA;
                of_s  = 1'b0;
            end
            default: begin
                alu_s = '0;
                of_s  = 1'b0;
            end
        endcase
    end

    // Per-icode result selection, condition, destination and error decode.
    always_comb begin
        vale_s  = '0;
        cnd_s   = 1'b0;
        err_s   = 1'b0;
        dste_s  = dstE;
        cc_we_s = 1'b0;
        case (icode)
            4'h2: begin
                if (ifun > 4'h6) begin
                    err_s  = 1'b1;
                    dste_s = RNONE;
                end else begin
                    vale_s = valA;
                    cnd_s  = cond_s;
                    // A cmov that is not taken must not write any register.
                    dste_s = cond_s ? dstE : RNONE;
                end
            end
            4'h3: begin
                vale_s = valC;
                cnd_s  = 1'b1;
            end
            4'h4, 4'h5: begin
                vale_s = valB + valC;
                cnd_s  = 1'b1;
            end
            4'h6: begin
                if (ifun <= 4'h3) begin
                    vale_s  = alu_s;
                    cnd_s   = 1'b1;
                    cc_we_s = cc_en;
                end else begin
                    err_s  = 1'b1;
                    dste_s = RNONE;
                end
            end
            4'h7: begin
                if (ifun > 4'h6) begin
                    err_s  = 1'b1;
                    dste_s = RNONE;
                end else begin
                    cnd_s = cond_s;
                end
            end
            4'h8, 4'hA: begin
                vale_s = valB - STEP_W;
                cnd_s  = 1'b1;
            end
            4'h9, 4'hB: begin
                vale_s = valB + STEP_W;
                cnd_s  = 1'b1;
            end
            default: begin
                vale_s = '0;
                cnd_s  = 1'b0;
            end
        endcase
    end

    // Result register, handshake state and condition-code register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_icode <= 4'h0;
            out_valE  <= '0;
            out_valA  <= '0;
            out_dstE  <= RNONE;
            out_cnd   <= 1'b0;
            out_err   <= 1'b0;
            cc_r      <= 3'b100;
        end else begin
            if (capture_s) begin
                out_valid <= 1'b1;
                out_icode <= icode;
                out_valE  <= vale_s;
                out_valA  <= valA;
                out_dstE  <= dste_s;
                out_cnd   <= cnd_s;
                out_err   <= err_s;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
            if (capture_s && cc_we_s) begin
                cc_r <= cc_next_s;
            end else begin
                cc_r <= cc_r;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_pipe.sv
module tb_execute_stage_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [3:0]  dstE;
    logic        cc_en;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [63:0] out_valE;
    logic [63:0] out_valA;
    logic [3:0]  out_dstE;
    logic        out_cnd;
    logic        out_err;
    logic [2:0]  cc_out;

    logic        in_valid32;
    logic        in_ready32;
    logic [3:0]  icode32;
    logic [3:0]  ifun32;
    logic [31:0] valA32;
    logic [31:0] valB32;
    logic [31:0] valC32;
    logic [3:0]  dstE32;
    logic        cc_en32;
    logic        out_valid32;
    logic        out_ready32;
    logic [3:0]  out_icode32;
    logic [31:0] out_valE32;
    logic [31:0] out_valA32;
    logic [3:0]  out_dstE32;
    logic        out_cnd32;
    logic        out_err32;
    logic [2:0]  cc_out32;

    int total;
    int bad;

    execute_stage_pipe #(.WIDTH(64), .STACK_STEP(8), .RNONE(4'hF)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .dstE(dstE), .cc_en(cc_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_valE(out_valE), .out_valA(out_valA),
        .out_dstE(out_dstE), .out_cnd(out_cnd), .out_err(out_err), .cc_out(cc_out)
    );

    execute_stage_pipe #(.WIDTH(32), .STACK_STEP(8), .RNONE(4'hF)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .icode(icode32), .ifun(ifun32), .valA(valA32), .valB(valB32), .valC(valC32),
        .dstE(dstE32), .cc_en(cc_en32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out_icode(out_icode32), .out_valE(out_valE32), .out_valA(out_valA32),
        .out_dstE(out_dstE32), .out_cnd(out_cnd32), .out_err(out_err32), .cc_out(cc_out32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [3:0] d,
                         input logic en, input logic v);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c; dstE = d; cc_en = en; in_valid = v;
    endtask

    // Reference result of one instruction: expected outputs and the new flags.
    typedef struct packed {
        logic [63:0] vale;
        logic        cnd;
        logic [3:0]  dst;
        logic        err;
        logic [2:0]  cc;
    } res_t;

    function automatic res_t ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c, input logic [3:0] d,
                                      input logic en, input logic [2:0] cc);
        res_t r;
        logic zf, sf, of, taken, ovf;
        logic [64:0] wide;
        zf = cc[2]; sf = cc[1]; of = cc[0];
        // Signed "less than" holds when SF differs from OF.
        case (fn)
            4'd0: taken = 1'b1;
            4'd1: taken = (sf != of) || zf;
            4'd2: taken = (sf != of);
            4'd3: taken = zf;
            4'd4: taken = !zf;
            4'd5: taken = (sf == of);
            4'd6: taken = (sf == of) && !zf;
            default: taken = 1'b0;
        endcase
        r.vale = 64'd0; r.cnd = 1'b0; r.dst = d; r.err = 1'b0; r.cc = cc;
        ovf = 1'b0; wide = 65'd0;
        case (ic)
            4'h2: if (fn > 4'd6) begin r.err = 1'b1; r.dst = 4'hF; end
                  else begin r.vale = a; r.cnd = taken; r.dst = taken ? d : 4'hF; end
            4'h3: begin r.vale = c; r.cnd = 1'b1; end
            4'h4, 4'h5: begin r.vale = b + c; r.cnd = 1'b1; end
            4'h6: begin
                if (fn > 4'd3) begin r.err = 1'b1; r.dst = 4'hF; end
                else begin
                    // Overflow: the exact signed result does not fit in 64 bits.
                    if (fn == 4'd0) begin wide = {b[63], b} + {a[63], a}; ovf = wide[64] != wide[63]; end
                    else if (fn == 4'd1) begin wide = {b[63], b} - {a[63], a}; ovf = wide[64] != wide[63]; end
                    else if (fn == 4'd2) wide = {1'b0, b & a};
                    else wide = {1'b0, b ^ a};
                    r.vale = wide[63:0];
                    r.cnd = 1'b1;
                    if (en) r.cc = {r.vale == 64'd0, r.vale[63], ovf};
                end
            end
            4'h7: if (fn > 4'd6) begin r.err = 1'b1; r.dst = 4'hF; end
                  else r.cnd = taken;
            4'h8, 4'hA: begin r.vale = b - 64'd8; r.cnd = 1'b1; end
            4'h9, 4'hB: begin r.vale = b + 64'd8; r.cnd = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    typedef struct packed {
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [3:0]  d;
        logic        en;
        logic [63:0] e_vale;
        logic        e_cnd;
        logic [3:0]  e_dst;
        logic        e_err;
        logic [2:0]  e_cc;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    res_t        mres;
    logic        mvalid;
    logic [2:0]  cc_m;
    logic [3:0]  micode;
    logic [63:0] mvalA;
    logic [63:0] corner [6];

    initial begin
        total = 0; bad = 0;
        tbl[0]  = '{4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 1'b1, 64'd0, 1'b1, 4'h2, 1'b0, 3'b100};
        tbl[1]  = '{4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF, 1'b1, 64'd0, 1'b1, 4'hF, 1'b0, 3'b100};
        tbl[2]  = '{4'h7, 4'h6, 64'd0, 64'd0, 64'h40, 4'hF, 1'b1, 64'd0, 1'b0, 4'hF, 1'b0, 3'b100};
        tbl[3]  = '{4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h5, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'h5, 1'b0, 3'b011};
        tbl[4]  = '{4'h2, 4'h2, 64'h55, 64'd0, 64'd0, 4'h3, 1'b1, 64'h55, 1'b0, 4'hF, 1'b0, 3'b011};
        tbl[5]  = '{4'h6, 4'h3, 64'hAA, 64'hAA, 64'd0, 4'h4, 1'b0, 64'd0, 1'b1, 4'h4, 1'b0, 3'b011};
        tbl[6]  = '{4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 1'b1, 64'hF8, 1'b1, 4'h4, 1'b0, 3'b011};
        tbl[7]  = '{4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 1'b1, 64'h108, 1'b1, 4'h4, 1'b0, 3'b011};
        tbl[8]  = '{4'h6, 4'h7, 64'd1, 64'd2, 64'd0, 4'h6, 1'b1, 64'd0, 1'b0, 4'hF, 1'b1, 3'b011};
        tbl[9]  = '{4'h8, 4'h0, 64'd0, 64'h200, 64'd0, 4'h4, 1'b1, 64'h1F8, 1'b1, 4'h4, 1'b0, 3'b011};
        tbl[10] = '{4'h9, 4'h0, 64'd0, 64'h200, 64'd0, 4'h4, 1'b1, 64'h208, 1'b1, 4'h4, 1'b0, 3'b011};
        tbl[11] = '{4'h4, 4'h0, 64'd0, 64'h10, 64'h20, 4'hF, 1'b1, 64'h30, 1'b1, 4'hF, 1'b0, 3'b011};
        tbl[12] = '{4'h5, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'h1, 1'b1, 64'd1, 1'b1, 4'h1, 1'b0, 3'b011};
        tbl[13] = '{4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h2, 1'b1, 64'h1234, 1'b1, 4'h2, 1'b0, 3'b011};
        tbl[14] = '{4'h7, 4'h0, 64'd0, 64'd0, 64'h80, 4'hF, 1'b1, 64'd0, 1'b1, 4'hF, 1'b0, 3'b011};
        tbl[15] = '{4'h2, 4'h1, 64'h77, 64'd0, 64'd0, 4'h7, 1'b1, 64'h77, 1'b0, 4'hF, 1'b0, 3'b011};
        tbl[16] = '{4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 1'b1, 64'd0, 1'b0, 4'hF, 1'b1, 3'b011};
        tbl[17] = '{4'h1, 4'h0, 64'd3, 64'd4, 64'd5, 4'h9, 1'b1, 64'd0, 1'b0, 4'h9, 1'b0, 3'b011};
        tbl[18] = '{4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'h1, 1'b0, 3'b010};
        tbl[19] = '{4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF, 1'b1, 64'd0, 1'b1, 4'hF, 1'b0, 3'b010};
        tbl[20] = '{4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 1'b1, 64'd0, 1'b0, 4'hF, 1'b0, 3'b010};
        tbl[21] = '{4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 4'hF, 1'b1, 64'd0, 1'b1, 4'hF, 1'b0, 3'b010};
        tbl[22] = '{4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b1, 64'd0, 1'b0, 4'hF, 1'b0, 3'b010};
        tbl[23] = '{4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h1, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'h1, 1'b0, 3'b001};
        tbl[24] = '{4'h2, 4'h5, 64'h99, 64'd0, 64'd0, 4'h8, 1'b1, 64'h99, 1'b0, 4'hF, 1'b0, 3'b001};
        tbl[25] = '{4'h2, 4'h2, 64'h98, 64'd0, 64'd0, 4'h8, 1'b1, 64'h98, 1'b1, 4'h8, 1'b0, 3'b001};
        tbl[26] = '{4'h6, 4'h2, 64'h0F, 64'hF0, 64'd0, 4'h2, 1'b1, 64'd0, 1'b1, 4'h2, 1'b0, 3'b100};
        tbl[27] = '{4'h2, 4'h3, 64'h11, 64'd0, 64'd0, 4'hA, 1'b1, 64'h11, 1'b1, 4'hA, 1'b0, 3'b100};
        tbl[28] = '{4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'h3, 1'b1,
                    64'd0, 1'b1, 4'h3, 1'b0, 3'b101};
        tbl[29] = '{4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 4'hF, 1'b1, 64'd0, 1'b1, 4'hF, 1'b0, 3'b101};
        tbl[30] = '{4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 4'hF, 1'b1, 64'd0, 1'b0, 4'hF, 1'b0, 3'b101};

        corner[0] = 64'h0; corner[1] = 64'h1; corner[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        corner[3] = 64'h7FFF_FFFF_FFFF_FFFF; corner[4] = 64'h8000_0000_0000_0000; corner[5] = 64'h8;

        // ---------------- reset and idle ----------------
        reset = 1'b1; out_ready = 1'b1;
        drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0);
        in_valid32 = 1'b0; out_ready32 = 1'b1; icode32 = 4'h0; ifun32 = 4'h0;
        valA32 = 32'd0; valB32 = 32'd0; valC32 = 32'd0; dstE32 = 4'hF; cc_en32 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("reset cc_out", cc_out, 3'b100);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_dstE", out_dstE, 4'hF);
        chk("reset out_valE", out_valE, 64'd0);
        chk("reset out_icode", out_icode, 4'h0);

        // ---------------- back-to-back table ----------------
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].ic, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].en, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d icode", i), out_icode, tbl[i].ic);
            chk($sformatf("vec%0d valE", i), out_valE, tbl[i].e_vale);
            chk($sformatf("vec%0d valA", i), out_valA, tbl[i].a);
            chk($sformatf("vec%0d cnd", i), out_cnd, tbl[i].e_cnd);
            chk($sformatf("vec%0d dstE", i), out_dstE, tbl[i].e_dst);
            chk($sformatf("vec%0d err", i), out_err, tbl[i].e_err);
            chk($sformatf("vec%0d cc", i), cc_out, tbl[i].e_cc);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain out_valid", out_valid, 1'b0);

        // ---------------- backpressure ----------------
        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h2, 1'b1, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h3, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            chk("stall valid", out_valid, 1'b1);
            chk("stall valE", out_valE, 64'h1234);
            chk("stall icode", out_icode, 4'h3);
            chk("stall cc", cc_out, 3'b101);
        end
        out_ready = 1'b1;
        #1 chk("release in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk("release icode", out_icode, 4'h6);
        chk("release valE", out_valE, 64'd2);
        chk("release cc", cc_out, 3'b000);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("release drain", out_valid, 1'b0);

        // ---------------- reset while stalled ----------------
        out_ready = 1'b0;
        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h55, 4'h2, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("pre-reset valid", out_valid, 1'b1);
        reset = 1'b1; out_ready = 1'b1;
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h3, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("stall reset valid", out_valid, 1'b0);
        chk("stall reset cc", cc_out, 3'b100);
        chk("stall reset dstE", out_dstE, 4'hF);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        // ---------------- WIDTH=32 instance ----------------
        icode32 = 4'h6; ifun32 = 4'h0; valA32 = 32'd1; valB32 = 32'd1; dstE32 = 4'h4;
        cc_en32 = 1'b1; in_valid32 = 1'b1;
        #1 chk("w32 in_ready", in_ready32, 1'b1);
        @(posedge clk); #1;
        chk("w32 add1 valE", out_valE32, 32'd2);
        chk("w32 add1 cc", cc_out32, 3'b000);
        valA32 = 32'hFFFF_FFFF; valB32 = 32'd1;
        @(posedge clk); #1;
        chk("w32 wrap valE", out_valE32, 32'd0);
        chk("w32 wrap cc", cc_out32, 3'b100);
        chk("w32 wrap valA", out_valA32, 32'hFFFF_FFFF);
        chk("w32 wrap dstE", out_dstE32, 4'h4);
        chk("w32 wrap cnd", out_cnd32, 1'b1);
        ifun32 = 4'h9;
        @(posedge clk); #1;
        chk("w32 illegal err", out_err32, 1'b1);
        chk("w32 illegal icode", out_icode32, 4'h6);
        chk("w32 illegal cc", cc_out32, 3'b100);
        in_valid32 = 1'b0;
        @(posedge clk); #1;
        chk("w32 drain", out_valid32, 1'b0);

        // ---------------- randomized against the reference model ----------------
        mvalid = 1'b0; cc_m = 3'b100; micode = 4'h0; mvalA = 64'd0; mres = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [3:0] ic_r;
            logic [63:0] a_r, b_r;
            if ($urandom_range(0, 4) == 0) ic_r = 4'($urandom_range(0, 15));
            else ic_r = 4'($urandom_range(2, 11));
            a_r = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : {$urandom, $urandom};
            b_r = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) b_r = a_r;
            if ($urandom_range(0, 7) == 0) b_r = -a_r;
            drive(ic_r, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
                  a_r, b_r, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 3) != 0;
            #1 chk("rnd in_ready", in_ready, !mvalid || out_ready);
            @(posedge clk);
            if (in_valid && (!mvalid || out_ready)) begin
                mres   = ref_exec(icode, ifun, valA, valB, valC, dstE, cc_en, cc_m);
                cc_m   = mres.cc;
                micode = icode;
                mvalA  = valA;
                mvalid = 1'b1;
            end else if (out_ready) begin
                mvalid = 1'b0;
            end
            #1;
            chk("rnd valid", out_valid, mvalid);
            chk("rnd cc", cc_out, cc_m);
            if (mvalid) begin
                chk("rnd icode", out_icode, micode);
                chk("rnd valE", out_valE, mres.vale);
                chk("rnd valA", out_valA, mvalA);
                chk("rnd dstE", out_dstE, mres.dst);
                chk("rnd cnd", out_cnd, mres.cnd);
                chk("rnd err", out_err, mres.err);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
